// File: rtl/data_mem_pkg.sv
// Shared constants and lane-geometry helpers for the byte-lane data memory.
// Pure declarations: no logic, no latency, no flow control.
package data_mem_pkg;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_ADDR_WIDTH   = 32;
  localparam int DEF_DEPTH_LOG2   = 17;
  localparam int DEF_READ_LATENCY = 1;

  function automatic int lanes_of(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int lsb_of(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/data_mem_bank_byte_lane_ram.sv
// One 8-bit lane of the data memory: synchronous write, synchronous registered read.
// Read data appears one edge after i_re and holds while i_re is low; no flow control.
module byte_lane_ram #(
  parameter int DEPTH_LOG2 = 17
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [7:0]            i_wdata,
  output logic [7:0]            o_rdata
);

  logic [7:0] r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_bank.sv
// Byte-lane data memory with in-order load/store responses after READ_LATENCY (1 or 2) cycles.
// Any held response (resp_valid && !resp_ready) freezes every stage and drops req_ready.
module data_mem_bank
  import data_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DEPTH_LOG2   = DEF_DEPTH_LOG2,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_req_valid,
  output logic                           o_req_ready,
  input  logic                           i_req_we,
  input  logic [ADDR_WIDTH-1:0]          i_req_addr,
  input  logic [lanes_of(DATA_WIDTH)-1:0] i_req_sel,
  input  logic [DATA_WIDTH-1:0]          i_req_wdata,
  output logic                           o_resp_valid,
  input  logic                           i_resp_ready,
  output logic [DATA_WIDTH-1:0]          o_resp_rdata,
  output logic                           o_resp_err
);

  localparam int NUM_LANES = lanes_of(DATA_WIDTH);
  localparam int LSB       = lsb_of(DATA_WIDTH);

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;
  } stage_t;

  logic                  w_stall;
  logic                  w_accept;
  logic                  w_err;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [DATA_WIDTH-1:0] w_ram_q;
  stage_t                w_s1;
  stage_t                w_out;
  logic                  w_unused;

  // Stage 1 keeps only flags; its data word lives in the lane RAM read registers.
  logic r_s1_vld;
  logic r_s1_err;
  logic r_s1_rd;

  assign w_stall     = w_out.valid & ~i_resp_ready;
  assign o_req_ready = ~w_stall;
  assign w_accept    = i_req_valid & ~w_stall;
  assign w_err       = (i_req_addr >> (DEPTH_LOG2 + LSB)) != '0;
  assign w_idx       = i_req_addr[DEPTH_LOG2+LSB-1:LSB];
  assign w_unused    = ^i_req_addr[LSB-1:0];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    byte_lane_ram #(
      .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
      .clk    (clk),
      .i_we   (w_accept & i_req_we & ~w_err & i_req_sel[g]),
      .i_re   (w_accept & ~i_req_we & ~w_err),
      .i_addr (w_idx),
      .i_wdata(i_req_wdata[8*g +: 8]),
      .o_rdata(w_ram_q[8*g +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_err <= 1'b0;
      r_s1_rd  <= 1'b0;
    end else if (!w_stall) begin
      r_s1_vld <= w_accept;
      r_s1_err <= w_accept & w_err;
      r_s1_rd  <= w_accept & ~i_req_we & ~w_err;
    end
  end

  assign w_s1.valid = r_s1_vld;
  assign w_s1.err   = r_s1_err;
  assign w_s1.rdata = r_s1_rd ? w_ram_q : '0;

  if (READ_LATENCY == 2) begin : g_lat2
    stage_t r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_s2 <= '0;
      else if (!w_stall) r_s2 <= w_s1;
    end

    assign w_out = r_s2;
  end else begin : g_lat1
    assign w_out = w_s1;
  end

  assign o_resp_valid = w_out.valid;
  assign o_resp_err   = w_out.err;
  assign o_resp_rdata = w_out.rdata;

endmodule

// File: tb/tb_data_mem_bank.sv
// Directed bench: three data_mem_bank instances share one request stream (A: defaults, B: latency 2, C: depth 16).
module tb_data_mem_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_sel = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_ready = 1'b1;

  logic        a_ready, a_valid, a_err;
  logic [31:0] a_rdata;
  logic        b_ready, b_valid, b_err;
  logic [31:0] b_rdata;
  logic        c_ready, c_valid, c_err;
  logic [31:0] c_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_bank u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(a_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_sel(req_sel), .i_req_wdata(req_wdata),
    .o_resp_valid(a_valid), .i_resp_ready(resp_ready), .o_resp_rdata(a_rdata), .o_resp_err(a_err)
  );

  data_mem_bank #(.READ_LATENCY(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(b_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_sel(req_sel), .i_req_wdata(req_wdata),
    .o_resp_valid(b_valid), .i_resp_ready(resp_ready), .o_resp_rdata(b_rdata), .o_resp_err(b_err)
  );

  data_mem_bank #(.DEPTH_LOG2(4)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(c_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_sel(req_sel), .i_req_wdata(req_wdata),
    .o_resp_valid(c_valid), .i_resp_ready(resp_ready), .o_resp_rdata(c_rdata), .o_resp_err(c_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [31:0] addr,
                       input logic [3:0] sel, input logic [31:0] wdata);
    req_valid = v;
    req_we    = we;
    req_addr  = addr;
    req_sel   = sel;
    req_wdata = wdata;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0b want 0", a_valid); end
    n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %0b want 0", a_err); end
    n_checks++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", a_rdata); end
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %0b want 1", a_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_byte_lane();
    drive(1'b1, 1'b1, 32'h100, 4'b1111, 32'hAABBCCDD);
    tick();
    n_checks++; if (a_valid !== 1'b1 || a_err !== 1'b0 || a_rdata !== 32'h0) begin
      n_fail++; $display("FAIL bl_ack1 got v=%0b e=%0b d=%h want v=1 e=0 d=0", a_valid, a_err, a_rdata); end
    drive(1'b1, 1'b1, 32'h100, 4'b0101, 32'h11223344);
    tick();
    n_checks++; if (a_valid !== 1'b1 || a_rdata !== 32'h0) begin
      n_fail++; $display("FAIL bl_ack2 got v=%0b d=%h want v=1 d=0", a_valid, a_rdata); end
    drive(1'b1, 1'b0, 32'h100, 4'b0000, 32'h0);
    tick();
    n_checks++; if (a_valid !== 1'b1 || a_err !== 1'b0 || a_rdata !== 32'hAA22CC44) begin
      n_fail++; $display("FAIL bl_load got v=%0b e=%0b d=%h want v=1 e=0 d=aa22cc44", a_valid, a_err, a_rdata); end
    idle(1);
    n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL bl_drain got %0b want 0", a_valid); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 32'h40, 4'b1111, 32'hDEADBEEF);
    tick();
    n_checks++; if (b_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_lat got %0b want 0", b_valid); end
    drive(1'b1, 1'b0, 32'h40, 4'b0000, 32'h0);
    tick();
    n_checks++; if (b_valid !== 1'b1 || b_err !== 1'b0 || b_rdata !== 32'h0) begin
      n_fail++; $display("FAIL b2b_ack got v=%0b e=%0b d=%h want v=1 e=0 d=0", b_valid, b_err, b_rdata); end
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();
    n_checks++; if (b_valid !== 1'b1 || b_err !== 1'b0 || b_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL b2b_load got v=%0b e=%0b d=%h want v=1 e=0 d=deadbeef", b_valid, b_err, b_rdata); end
    tick();
    n_checks++; if (b_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %0b want 0", b_valid); end
    idle(1);
  endtask

  task automatic test_range();
    drive(1'b1, 1'b1, 32'h0, 4'b1111, 32'h12345678);
    tick();
    n_checks++; if (c_valid !== 1'b1 || c_err !== 1'b0) begin
      n_fail++; $display("FAIL rng_ack0 got v=%0b e=%0b want v=1 e=0", c_valid, c_err); end
    drive(1'b1, 1'b0, 32'h40, 4'b0000, 32'h0);
    tick();
    n_checks++; if (c_valid !== 1'b1 || c_err !== 1'b1 || c_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rng_load got v=%0b e=%0b d=%h want v=1 e=1 d=0", c_valid, c_err, c_rdata); end
    drive(1'b1, 1'b1, 32'h44, 4'b1111, 32'hFFFFFFFF);
    tick();
    n_checks++; if (c_valid !== 1'b1 || c_err !== 1'b1 || c_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rng_st44 got v=%0b e=%0b d=%h want v=1 e=1 d=0", c_valid, c_err, c_rdata); end
    drive(1'b1, 1'b1, 32'h40, 4'b1111, 32'hFFFFFFFF);
    tick();
    n_checks++; if (c_valid !== 1'b1 || c_err !== 1'b1) begin
      n_fail++; $display("FAIL rng_st40 got v=%0b e=%0b want v=1 e=1", c_valid, c_err); end
    drive(1'b1, 1'b0, 32'h0, 4'b0000, 32'h0);
    tick();
    n_checks++; if (c_valid !== 1'b1 || c_err !== 1'b0 || c_rdata !== 32'h12345678) begin
      n_fail++; $display("FAIL rng_word0 got v=%0b e=%0b d=%h want v=1 e=0 d=12345678", c_valid, c_err, c_rdata); end
    idle(2);
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b1, 32'h200, 4'b1111, 32'h01010101); tick();
    drive(1'b1, 1'b1, 32'h204, 4'b1111, 32'h02020202); tick();
    drive(1'b1, 1'b1, 32'h208, 4'b1111, 32'h03030303); tick();
    idle(3);
    drive(1'b1, 1'b0, 32'h200, 4'b0000, 32'h0);
    tick();
    n_checks++; if (a_valid !== 1'b1 || a_rdata !== 32'h01010101) begin
      n_fail++; $display("FAIL stl_first got v=%0b d=%h want v=1 d=01010101", a_valid, a_rdata); end
    resp_ready = 1'b0;
    drive(1'b1, 1'b0, 32'h204, 4'b0000, 32'h0);
    #1;
    n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL stl_ready_comb got %0b want 0", a_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (a_valid !== 1'b1 || a_ready !== 1'b0 || a_rdata !== 32'h01010101) begin
        n_fail++; $display("FAIL stl_hold%0d got v=%0b r=%0b d=%h want v=1 r=0 d=01010101", i, a_valid, a_ready, a_rdata); end
    end
    resp_ready = 1'b1;
    tick();
    n_checks++; if (a_valid !== 1'b1 || a_rdata !== 32'h02020202) begin
      n_fail++; $display("FAIL stl_resume got v=%0b d=%h want v=1 d=02020202", a_valid, a_rdata); end
    drive(1'b1, 1'b0, 32'h208, 4'b0000, 32'h0);
    tick();
    n_checks++; if (a_valid !== 1'b1 || a_rdata !== 32'h03030303) begin
      n_fail++; $display("FAIL stl_next got v=%0b d=%h want v=1 d=03030303", a_valid, a_rdata); end
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();
    n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL stl_nodup got %0b want 0", a_valid); end
    idle(3);
  endtask

  task automatic test_reset_mid_stall();
    resp_ready = 1'b0;
    drive(1'b1, 1'b0, 32'h204, 4'b0000, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    n_checks++; if (a_valid !== 1'b1 || a_rdata !== 32'h02020202) begin
      n_fail++; $display("FAIL mrst_pre got v=%0b d=%h want v=1 d=02020202", a_valid, a_rdata); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (a_valid !== 1'b0 || a_err !== 1'b0 || a_rdata !== 32'h0) begin
      n_fail++; $display("FAIL mrst_now got v=%0b e=%0b d=%h want all 0", a_valid, a_err, a_rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    #1;
    n_checks++; if (a_ready !== 1'b1 || a_valid !== 1'b0) begin
      n_fail++; $display("FAIL mrst_after got r=%0b v=%0b want r=1 v=0", a_ready, a_valid); end
    tick();
  endtask

  initial begin
    test_reset();
    test_byte_lane();
    test_back_to_back();
    test_range();
    test_stall();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
